// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the parametrised register file.
// Optional write-to-read forwarding is selected by the REGFILE_BYPASS_EN macro.
package reg_file_pkg;

    localparam int REGFILE_DATA_W = 16;
    localparam int REGFILE_ADDR_W = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/reg_file_param_if.sv
// Decode-stage to register-file port bundle. Handshake: single-cycle strobe; writeEn is a
// one-edge write request, dropped without back-pressure while busy is high; reads are unconditional.
interface reg_file_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              writeEn;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] dstAddr;
    logic [ADDR_W-1:0] srcAddr;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              busy;

    modport master (
        output writeEn, writeData, dstAddr, srcAddr,
        input  readData1, readData2, busy
    );

    modport slave (
        input  writeEn, writeData, dstAddr, srcAddr,
        output readData1, readData2, busy
    );
endinterface

// File: rtl/reg_file_clear_ctrl.sv
// Post-reset clear sweep: walks clrAddr over every register once, then hands over to RUN.
module reg_file_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic            clk,
    input  logic            reset,
    output logic            busy,
    output logic            clrWe,
    output logic [ADDR_W:0] clrAddr,
    output state_t          state
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    assign clrWe = (state == CLEAR) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clrAddr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clrAddr <= clrAddr + (ADDR_W + 1)'(1);
                    if (clrAddr == LAST_ADDR) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    state <= RUN;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= CLEAR;
                    clrAddr <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/reg_file_param.sv
// DEPTH x DATA_W register file: one write port, two registered read ports, hardware clear sweep.
// Define REGFILE_BYPASS_EN for write-first forwarding; otherwise same-edge reads return old data.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int                DATA_W    = REGFILE_DATA_W,
    parameter int                ADDR_W    = REGFILE_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    reg_file_param_if.slave  bus,
    output state_t           dbgState
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              busy;
    logic              clrWe;
    logic [ADDR_W:0]   clrAddr;
    logic              inRun;
    logic              userWe;
    logic              fwd1;
    logic              fwd2;

    reg_file_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear_ctrl (
        .clk     (clk),
        .reset   (reset),
        .busy    (busy),
        .clrWe   (clrWe),
        .clrAddr (clrAddr),
        .state   (dbgState)
    );

    assign bus.busy = busy;
    assign inRun    = (dbgState == RUN);
    assign userWe   = inRun && bus.writeEn;

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = userWe;
    assign fwd2 = userWe && (bus.srcAddr == bus.dstAddr);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // The counter MSB only rises after the last address is cleared; it gates stray sweep writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clrWe && !clrAddr[ADDR_W]) begin
                mem[clrAddr[ADDR_W-1:0]] <= CLEAR_VAL;
            end else if (userWe) begin
                mem[bus.dstAddr] <= bus.writeData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !inRun) begin
            bus.readData1 <= CLEAR_VAL;
            bus.readData2 <= CLEAR_VAL;
        end else begin
            bus.readData1 <= fwd1 ? bus.writeData : mem[bus.dstAddr];
            bus.readData2 <= fwd2 ? bus.writeData : mem[bus.srcAddr];
        end
    end
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: sweep timing, table of write/read vectors, mid-sweep reset.
module tb_reg_file_param;
    import reg_file_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic   clk;
    logic   reset;
    state_t dbgState;
    int     nChecks;
    int     nFails;

    reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .CLEAR_VAL(16'h0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .dbgState (dbgState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] data;
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [15:0] data, input logic [3:0] dst,
                         input logic [3:0] src);
        bus.writeEn   = we;
        bus.writeData = data;
        bus.dstAddr   = dst;
        bus.srcAddr   = src;
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        reset   = 1'b1;
        drive(1'b0, 16'h0000, 4'd0, 4'd0);

        vecs[0]  = '{1'b1, 16'h0002, 4'd1,  4'd0,  BYP ? 16'h0002 : 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0000, 4'd1,  4'd1,  16'h0002, 16'h0002};
        vecs[2]  = '{1'b1, 16'hBEEF, 4'd5,  4'd5,  BYP ? 16'hBEEF : 16'h0000, BYP ? 16'hBEEF : 16'h0000};
        vecs[3]  = '{1'b0, 16'h0000, 4'd5,  4'd5,  16'hBEEF, 16'hBEEF};
        vecs[4]  = '{1'b1, 16'h0003, 4'd3,  4'd1,  BYP ? 16'h0003 : 16'h0000, 16'h0002};
        vecs[5]  = '{1'b1, 16'h000C, 4'd12, 4'd3,  BYP ? 16'h000C : 16'h0000, 16'h0003};
        vecs[6]  = '{1'b0, 16'h0000, 4'd3,  4'd12, 16'h0003, 16'h000C};
        vecs[7]  = '{1'b1, 16'hFFFF, 4'd15, 4'd0,  BYP ? 16'hFFFF : 16'h0000, 16'h0000};
        vecs[8]  = '{1'b1, 16'h5A5A, 4'd15, 4'd15, BYP ? 16'h5A5A : 16'hFFFF, BYP ? 16'h5A5A : 16'hFFFF};
        vecs[9]  = '{1'b0, 16'h0000, 4'd15, 4'd5,  16'h5A5A, 16'hBEEF};
        vecs[10] = '{1'b0, 16'h0000, 4'd0,  4'd15, 16'h0000, 16'h5A5A};
        vecs[11] = '{1'b1, 16'h1111, 4'd8,  4'd9,  BYP ? 16'h1111 : 16'h0000, 16'h0000};
        vecs[12] = '{1'b0, 16'h0000, 4'd9,  4'd8,  16'h0000, 16'h1111};
        vecs[13] = '{1'b0, 16'h7777, 4'd8,  4'd8,  16'h1111, 16'h1111};

        // Reset held for two edges.
        tick();
        tick();
        check("reset_busy", 32'(bus.busy), 32'd1);
        check("reset_rd1", 32'(bus.readData1), 32'h0);
        check("reset_rd2", 32'(bus.readData2), 32'h0);
        check("reset_state", 32'(dbgState), 32'(CLEAR));

        // Sweep with a write held on the whole time, including the edge busy falls.
        reset = 1'b0;
        drive(1'b1, 16'h1234, 4'd7, 4'd7);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("sweep_busy_%0d", i), 32'(bus.busy), (i < 16) ? 32'd1 : 32'd0);
            check($sformatf("sweep_rd1_%0d", i), 32'(bus.readData1), 32'h0);
            check($sformatf("sweep_rd2_%0d", i), 32'(bus.readData2), 32'h0);
        end
        check("sweep_state_run", 32'(dbgState), 32'(RUN));
        bus.writeEn = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 16'h0000, 4'(i), 4'(15 - i));
            tick();
            check($sformatf("clear_rd1_r%0d", i), 32'(bus.readData1), 32'h0);
            check($sformatf("clear_rd2_r%0d", 15 - i), 32'(bus.readData2), 32'h0);
        end

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].we, vecs[i].data, vecs[i].dst, vecs[i].src);
            tick();
            check($sformatf("vec%0d_rd1", i), 32'(bus.readData1), 32'(vecs[i].e1));
            check($sformatf("vec%0d_rd2", i), 32'(bus.readData2), 32'(vecs[i].e2));
        end

        // Reset partway through a sweep restarts it and clears earlier writes.
        drive(1'b1, 16'h00AA, 4'd2, 4'd0);
        tick();
        drive(1'b1, 16'h00BB, 4'd14, 4'd0);
        tick();
        drive(1'b0, 16'h0000, 4'd2, 4'd14);
        tick();
        check("pre_reset_r2", 32'(bus.readData1), 32'h00AA);
        check("pre_reset_r14", 32'(bus.readData2), 32'h00BB);

        reset = 1'b1;
        tick();
        check("rst2_rd1", 32'(bus.readData1), 32'h0);
        check("rst2_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("part_busy_%0d", i), 32'(bus.busy), 32'd1);
        end
        reset = 1'b1;
        tick();
        check("mid_reset_state", 32'(dbgState), 32'(CLEAR));
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("resweep_busy_%0d", i), 32'(bus.busy), (i < 16) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 16'h0000, 4'd2, 4'd14);
        tick();
        check("post_sweep_r2", 32'(bus.readData1), 32'h0);
        check("post_sweep_r14", 32'(bus.readData2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the 16x16 processor register file: DEPTH x DATA_W storage, one write port, two registered read ports (destination and source operand). Adds a post-reset hardware clear sweep with a `busy` flag and optional write-to-read forwarding. It sits between the decode stage (which supplies addresses) and the ALU operand muxes (which consume `readData1` and `readData2`).

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- CLEAR_VAL, 0, DATA_W-bit value written to every register by the clear sweep

- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- writeEn  in  1  write strobe; sampled on the rising edge
- writeData  in  DATA_W  write data
- dstAddr  in  ADDR_W  write address and read port 1 address
- srcAddr  in  ADDR_W  read port 2 address
- readData1  out  DATA_W  registered contents of mem[dstAddr]
- readData2  out  DATA_W  registered contents of mem[srcAddr]
- busy  out  1  high while the clear sweep is in progress; writes ignored

## Operation
- States: CLEAR and RUN.
- reset high at an edge:
  - Next state is CLEAR, with clrAddr = 0.
  - readData1 = readData2 = CLEAR_VAL and busy = 1.
  - No memory write occurs while reset is held.
- CLEAR (reset low):
  - Each edge writes CLEAR_VAL to mem[clrAddr], then clrAddr increments.
  - The edge that writes address DEPTH-1 moves the state to RUN and drives busy to 0.
  - writeEn is ignored. Read outputs stay at CLEAR_VAL.
- RUN:
  - If writeEn = 1, mem[dstAddr] <= writeData.
  - readData1 <= mem[dstAddr] and readData2 <= mem[srcAddr], every edge.
- Same-edge write and read of the same address: the result depends on REGFILE_BYPASS_EN (see Configuration). This applies to both ports independently.
- reset during a sweep restarts the sweep at address 0. reset takes priority over every other input.
- clrAddr is ADDR_W+1 bits wide, so its terminal compare is unambiguous. Memory is indexed with clrAddr[ADDR_W-1:0].
- No arithmetic is performed on data. Addresses are unsigned and always in range (DEPTH = 2**ADDR_W).

## Timing
- Read latency is 1 cycle: an address presented before edge N appears on readData after edge N.
- Write commits at the edge where writeEn = 1. Readable through the array from edge N+1 onward.
- busy stays high from the first reset edge through exactly DEPTH edges after reset is released. busy = 0 first appears after the DEPTH-th post-reset edge.
- Reset values:
  - readData1 = CLEAR_VAL
  - readData2 = CLEAR_VAL
  - busy = 1
  - state = CLEAR, clrAddr = 0
- A write presented on the same edge that busy falls is ignored. The first accepted write is on the following edge.

## Configuration
- REGFILE_BYPASS_EN defined: write-first forwarding.
  - A read whose address equals dstAddr with writeEn = 1 in RUN registers writeData.
  - readData1 therefore shows the new value 1 cycle after the write.
- REGFILE_BYPASS_EN undefined: read-first.
  - The same-edge read returns the old contents.
  - The new value appears one cycle later.

## Structure
- Shared package reg_file_pkg:
  - state enum {CLEAR, RUN}.
  - Default constants REGFILE_DATA_W = 16 and REGFILE_ADDR_W = 4.
- Sub-module reg_file_clear_ctrl:
  - Holds the sweep FSM and clrAddr counter.
  - Outputs busy, clrWe and clrAddr.
- The top level contains the memory array, write mux (clear vs. user), read registers and bypass compare.

## Test plan
- Reset sweep: hold reset 2 cycles, release.
  - busy = 1 for exactly 16 edges, then 0.
  - All 16 registers read back 0; readData1/2 = 0 throughout.
- Basic write/read: writeEn = 1, dstAddr = 1, writeData = 16'd2; next cycle dstAddr = srcAddr = 1.
  - readData1 = readData2 = 2.
- Forwarding: write 16'hBEEF to r5 with dstAddr = srcAddr = 5 on the same edge.
  - With REGFILE_BYPASS_EN: both read ports show BEEF one cycle later.
  - Without it: they show the old value 0, then BEEF the following cycle.
- Dual port: write r3 = 16'h0003 and r12 = 16'h000C; then dstAddr = 3, srcAddr = 12.
  - readData1 = 3 and readData2 = 12 in the same cycle.
- Busy write drop: during the sweep, writeEn = 1, dstAddr = 7, writeData = 16'h1234.
  - After the sweep, r7 reads 0.
- Reset mid-sweep: assert reset at sweep cycle 8.
  - busy stays high for 16 further edges after release.
  - A register written before reset (r2 = 16'h00AA) reads 0 afterward.
